switch_input_port: RTL and testbench
====================================

# switch_input_port

Input-side peripheral for the switch bank: synchronizes the raw asynchronous `switches` pins, debounces each bit independently, and records per-bit sticky change flags with an interrupt line. The processor core reads the debounced level or the change flags over a one-cycle-latency read port; reading the flags clears them. It is the input counterpart to the LED output path and sits between the board pins and the core's I/O decode.

## Interface

- `WIDTH`, 4: number of switch bits.
- `DEBOUNCE_CYCLES`, 100000: consecutive clock cycles a synchronized bit must differ from its debounced level before the level flips (1 ms at 100 MHz). Legal range ≥ 1.

- `clock`  in  1  system clock, 100 MHz, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `switches`  in  WIDTH  raw switch pins, asynchronous to `clock`.
- `state`  out  WIDTH  debounced switch level (registered).
- `changed`  out  WIDTH  sticky per-bit flag: debounced level of that bit has flipped since last clear (registered).
- `irq`  out  1  OR-reduction of `changed`.
- `rd_en`  in  1  read strobe, sampled on rising edge.
- `rd_addr`  in  1  0 = read `state`, 1 = read-and-clear `changed`.
- `rd_data`  out  WIDTH  read result, registered.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_data`.

## Operation

- Reset (while `reset` low): synchronizer flops, counters, `state`, `changed`, `rd_data`, `rd_valid` all 0; `irq` therefore 0.
- Synchronizer: two flops per bit (`sync1`, `sync2`); no logic between them.
- Per-bit debounce FSM, two states:
  - STABLE: `sync2 == state[i]`, counter held at 0. `sync2 != state[i]` → PENDING, counter becomes 1.
  - PENDING: each edge with `sync2 != state[i]` increments counter. Edge where counter == DEBOUNCE_CYCLES−1 and bit still differs → `state[i]` toggles, `changed[i]` set, counter to 0, → STABLE. Any edge with `sync2 == state[i]` → counter to 0, → STABLE, no flag.
- Counter width: $clog2(DEBOUNCE_CYCLES+1); never wraps (cleared at terminal count).
- DEBOUNCE_CYCLES = 1: flip on the first edge where `sync2` differs; PENDING never occupied.
- Read port: on an edge with `rd_en` high, `rd_data` ← `state` (addr 0) or `changed` (addr 1), using values before that edge; `rd_valid` ← 1. Otherwise `rd_valid` ← 0, `rd_data` holds.
- Addr 1 read clears exactly the bits returned. A bit set by a debounce flip on the same edge stays set (set wins over clear) and is not in `rd_data`.
- `rd_en` held high: one independent read per cycle, `rd_valid` stays high.
- Addr 0 read has no side effect.

## Timing

- Switch change set up before edge 0 and held: `sync2` updates at edge 1; `state` and `changed` update at edge DEBOUNCE_CYCLES+1; `irq` high in the same cycle.
- Pulses shorter than DEBOUNCE_CYCLES cycles at `sync2` are rejected entirely.
- Read latency: `rd_en` sampled at edge n → `rd_data`/`rd_valid` valid after edge n, for one cycle.
- `changed` clear visible after edge n; `irq` drops the same cycle if no other bit set.
- Reset asserted mid-PENDING: counters and `state` clear immediately; after release, held switch levels re-debounce from zero and set `changed`.

## Test plan

Bench runs DEBOUNCE_CYCLES = 4, 10 ns clock.

- Reset low, `switches`=0000 → `state`, `changed`, `rd_data`=0000, `irq`=0, `rd_valid`=0; release → all remain 0.
- `switches` 0000→0101 before edge 0, held → `state`=0101 and `changed`=0101 exactly after edge 5, `irq`=1; unchanged before edge 5.
- Bit 0 high for 3 cycles then low → `state` and `changed` never change, `irq` stays 0.
- `rd_en`=1, `rd_addr`=0 → `rd_data`=0101, `rd_valid` pulse, `changed` still 0101; then `rd_addr`=1 → `rd_data`=0101, `changed`=0000, `irq`=0 next cycle.
- Bit 3 flip completing on the same edge as an addr-1 read with `changed`=0001 → `rd_data`=0001, `changed`=1000 afterward, `irq` stays 1.
- `state`=0101, `switches` held 0101, reset pulsed low mid-PENDING of bit 1 → `state`=0000 immediately; after release `state`=0101, `changed`=0101 exactly 5 edges after the first edge following release.

Source files
------------

// File: rtl/switch_input_port.sv
// ============================================================================
// Module      : switch_input_port
// Description : Synchronizes and debounces a switch bank, keeps sticky per-bit
//               change flags with an interrupt, and serves a one-cycle read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module switch_input_port #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] changed,
  output logic             irq,
  input  logic             rd_en,
  input  logic             rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
  localparam logic               c_stable  = 1'b0;
  localparam logic               c_pending = 1'b1;

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_state;
  logic [WIDTH-1:0]   r_changed;
  logic [WIDTH-1:0]   r_fsm;
  logic [c_cnt_w-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]   r_rd_data;
  logic               r_rd_valid;

  logic [WIDTH-1:0]   w_differ;
  logic [WIDTH-1:0]   w_flip;
  logic [WIDTH-1:0]   w_clear;

  // In STABLE the counter is 0, so with DEBOUNCE_CYCLES == 1 the first
  // differing edge already hits terminal count and PENDING is skipped.
  always_comb begin
    w_differ = r_sync2 ^ r_state;
    w_flip   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_flip[i] = w_differ[i] && (r_cnt[i] == c_last);
    end
  end

  // Only flags actually returned by a flag read are cleared; new flips win.
  assign w_clear = (rd_en && rd_addr) ? r_changed : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_state    <= '0;
      r_changed  <= '0;
      r_fsm      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;

      for (int i = 0; i < WIDTH; i++) begin
        case (r_fsm[i])
          c_stable: begin
            if (w_differ[i] && !w_flip[i]) begin
              r_fsm[i] <= c_pending;
              r_cnt[i] <= c_one;
            end
          end
          default: begin
            if (!w_differ[i] || w_flip[i]) begin
              r_fsm[i] <= c_stable;
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + c_one;
            end
          end
        endcase
      end

      r_state   <= r_state ^ w_flip;
      r_changed <= (r_changed & ~w_clear) | w_flip;

      if (rd_en) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= rd_addr ? r_changed : r_state;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign state    = r_state;
  assign changed  = r_changed;
  assign irq      = |r_changed;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_switch_input_port.sv
// ============================================================================
// Module      : tb_switch_input_port
// Description : Randomized and directed bench for switch_input_port against a
//               sample-window reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_switch_input_port;

  localparam int c_w  = 4;
  localparam int c_dc = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [c_w-1:0] switches = '0;
  logic [c_w-1:0] state;
  logic [c_w-1:0] changed;
  logic           irq;
  logic           rd_en = 1'b0;
  logic           rd_addr = 1'b0;
  logic [c_w-1:0] rd_data;
  logic           rd_valid;

  int checks   = 0;
  int failures = 0;

  switch_input_port #(
    .WIDTH          (c_w),
    .DEBOUNCE_CYCLES(c_dc)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .switches(switches),
    .state   (state),
    .changed (changed),
    .irq     (irq),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bit flips once its last c_dc synchronized samples all
  // disagree with its current level. The synchronizer is a plain 2-deep delay.
  logic [c_w-1:0] m_s1, m_s2, e_state, e_changed, e_rd_data, m_flip;
  logic           e_rd_valid;
  logic [c_w-1:0] hist[$];
  logic           all_diff;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; e_state = '0; e_changed = '0;
      e_rd_data = '0; e_rd_valid = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > c_dc) void'(hist.pop_front());
      m_flip = '0;
      if (hist.size() == c_dc) begin
        for (int b = 0; b < c_w; b++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][b] == e_state[b]) all_diff = 1'b0;
          m_flip[b] = all_diff;
        end
      end
      if (rd_en) begin
        e_rd_valid = 1'b1;
        e_rd_data  = rd_addr ? e_changed : e_state;
        if (rd_addr) e_changed = '0;
      end else begin
        e_rd_valid = 1'b0;
      end
      e_changed = e_changed | m_flip;
      e_state   = e_state ^ m_flip;
      m_s2 = m_s1;
      m_s1 = switches;
    end
  end

  always @(negedge clock) begin
    check("model_state",    32'(state),    32'(e_state));
    check("model_changed",  32'(changed),  32'(e_changed));
    check("model_irq",      32'(irq),      32'(|e_changed));
    check("model_rd_valid", 32'(rd_valid), 32'(e_rd_valid));
    check("model_rd_data",  32'(rd_data),  32'(e_rd_data));
  end

  // Inputs change 2 ns after a rising edge, so the next edge is "edge 0".
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_state", 32'(state), 32'h0);
    check("rst_changed", 32'(changed), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    reset = 1'b1;
    tick(4);
    check("post_rst_state", 32'(state), 32'h0);
    check("post_rst_changed", 32'(changed), 32'h0);

    // Short pulse on bit 0 is rejected
    switches = 4'b0001;
    tick(3);
    switches = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch_state", 32'(state), 32'h0);
      check("glitch_irq", 32'(irq), 32'h0);
    end

    // Held change flips exactly after edge DEBOUNCE_CYCLES+1
    switches = 4'b0101;
    for (int k = 0; k <= 5; k++) begin
      tick(1);
      check("deb_state", 32'(state), (k == 5) ? 32'h5 : 32'h0);
      check("deb_changed", 32'(changed), (k == 5) ? 32'h5 : 32'h0);
    end
    check("deb_irq", 32'(irq), 32'h1);

    // Level read, then flag read-and-clear
    rd_en = 1'b1; rd_addr = 1'b0;
    tick(1);
    check("rd0_data", 32'(rd_data), 32'h5);
    check("rd0_valid", 32'(rd_valid), 32'h1);
    check("rd0_changed", 32'(changed), 32'h5);
    rd_addr = 1'b1;
    tick(1);
    check("rd1_data", 32'(rd_data), 32'h5);
    check("rd1_valid", 32'(rd_valid), 32'h1);
    check("rd1_changed", 32'(changed), 32'h0);
    check("rd1_irq", 32'(irq), 32'h0);
    rd_en = 1'b0;
    tick(1);
    check("rd_valid_drop", 32'(rd_valid), 32'h0);
    check("rd_data_hold", 32'(rd_data), 32'h5);

    // Set wins over clear on the same edge
    switches = 4'b0100;
    tick(8);
    check("pre_sc_changed", 32'(changed), 32'h1);
    switches = 4'b1100;
    tick(5);
    rd_en = 1'b1; rd_addr = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("sc_rd_data", 32'(rd_data), 32'h1);
    check("sc_changed", 32'(changed), 32'h8);
    check("sc_irq", 32'(irq), 32'h1);
    check("sc_state", 32'(state), 32'hC);

    // Reset mid-PENDING, then re-debounce of held levels
    switches = 4'b0101;
    tick(8);
    rd_en = 1'b1; rd_addr = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("pre_rst_state", 32'(state), 32'h5);
    switches = 4'b0111;
    tick(4);
    switches = 4'b0101;
    reset = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'h0);
    tick(2);
    reset = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick(1);
      check("rerun_state", 32'(state), (k == 5) ? 32'h5 : 32'h0);
      check("rerun_changed", 32'(changed), (k == 5) ? 32'h5 : 32'h0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) switches = c_w'($urandom);
      rd_en   = ($urandom_range(0, 2) == 0);
      rd_addr = 1'($urandom);
      tick(1);
    end
    rd_en = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
